// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared constants for the instruction/data-side AXI read bridges.
// Holds AXI encodings, the kseg0/kseg1 mask and the fetch bridge FSM states.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] KSEG01_MASK    = 32'h1FFF_FFFF;

  localparam logic [1:0] IBR_IDLE = 2'd0;
  localparam logic [1:0] IBR_AR   = 2'd1;
  localparam logic [1:0] IBR_R    = 2'd2;

  // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) both have top bits 2'b10.
  function automatic logic is_kseg01(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10);
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_addr_map_kseg.sv
// Virtual-to-physical map for unmapped MIPS segments; purely combinational.
// kseg0/kseg1 fold onto the low 512 MB, every other address passes through.
module addr_map_kseg
  import inst_axi_rd_bridge_pkg::*;
(
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  assign o_paddr = is_kseg01(i_vaddr) ? (i_vaddr & KSEG01_MASK) : i_vaddr;

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side sram-like to single-beat AXI4 read bridge, one transaction in flight.
// Latency req->data_ok is 2 cycles minimum; AR and R stalls simply hold the FSM.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [31:0]       inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,
  output logic [3:0]        arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              bus_err
);

  logic [1:0]  r_state;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [31:0] w_paddr;
  logic        w_unused;

  addr_map_kseg u_addr_map (
    .i_vaddr (inst_sram_addr),
    .o_paddr (w_paddr)
  );

  // Single-beat reads: rlast is not needed to end the burst, and rid is never checked.
  assign w_unused = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IBR_IDLE;
      r_araddr <= '0;
      r_arsize <= '0;
    end else begin
      case (r_state)
        IBR_IDLE: begin
          if (inst_sram_req) begin
            r_state  <= IBR_AR;
            r_araddr <= w_paddr;
            r_arsize <= {1'b0, inst_sram_size};
          end
        end
        IBR_AR: begin
          if (arready) r_state <= IBR_R;
        end
        IBR_R: begin
          if (rvalid) r_state <= IBR_IDLE;
        end
        default: r_state <= IBR_IDLE;
      endcase
    end
  end

  assign inst_sram_addr_ok = (r_state == IBR_IDLE) && inst_sram_req;
  assign arvalid           = (r_state == IBR_AR);
  assign rready            = (r_state == IBR_R);
  assign inst_sram_data_ok = rready && rvalid;
  assign inst_sram_rdata   = rdata;
  assign bus_err           = inst_sram_data_ok && (rresp != AXI_RESP_OKAY);

  assign arid    = AXI_ID;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = r_arsize;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge: random fetches against a randomly
// stalling AXI slave, checked by an independent negedge monitor.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, bus_err;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.AXI_ID(4'd0), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Segment arithmetic straight from the MIPS memory map.
  function automatic logic [31:0] model_map(input logic [31:0] va);
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
    return va;
  endfunction

  // Expected AR beats {arsize, araddr} and R completions {bus_err, data}.
  logic [34:0] ar_q[$];
  logic [32:0] d_q[$];

  // Slave knobs.
  int          ar_pct    = 100;
  int          r_dly_min = 0;
  int          r_dly_max = 0;
  logic        fix_en    = 1'b0;
  logic [31:0] fix_data  = '0;
  logic [1:0]  fix_resp  = '0;
  logic        stray_rv  = 1'b0;

  // Transaction lifecycle: 0 free, 1 address issued, 2 awaiting data.
  int ph = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_dok = 0;
  int n_dok = 0;
  int n_err = 0;
  logic [32:0] d_exp;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      ph = 0;
      ar_q.delete();
      d_q.delete();
    end else begin
      chk("addr_ok", addr_ok, (ph == 0) && req);
      chk("arvalid", arvalid, ph == 1);
      chk("rready", rready, ph == 2);
      chk("data_ok", data_ok, (ph == 2) && rvalid);
      if (ph == 1 && ar_q.size() > 0) begin
        chk("araddr", araddr, ar_q[0][31:0]);
        chk("arsize", arsize, ar_q[0][34:32]);
        chk("ar_fixed", {arid, arlen, arburst, arlock, arcache, arprot}, {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
      if (data_ok) begin
        n_dok++;
        t_dok = cyc;
        chk("d_q_nonempty", d_q.size() > 0, 1);
        if (d_q.size() > 0) begin
          d_exp = d_q.pop_front();
          chk("rdata", sram_rdata, d_exp[31:0]);
          chk("bus_err", bus_err, d_exp[32]);
          if (d_exp[32]) n_err++;
        end
      end else begin
        chk("bus_err_quiet", bus_err, 0);
      end
      if (ph == 0 && req) begin
        ph = 1;
        t_acc = cyc;
      end else if (ph == 1 && arready) begin
        ph = 2;
        if (ar_q.size() > 0) void'(ar_q.pop_front());
      end else if (ph == 2 && rvalid) begin
        ph = 0;
      end
    end
  end

  // AXI slave: random AR stalls, programmable R delay, pushes the data it returns.
  initial begin
    int   cnt;
    bit   pend, on, raise;
    logic [1:0]  resp;
    logic [31:0] dat;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    pend = 0; on = 0; cnt = 0;
    forever begin
      @(negedge clk);
      raise = 0;
      if (reset) begin
        pend = 0;
        on = 0;
      end else begin
        if (on && rready) begin
          on = 0;
          pend = 0;
        end
        if (arvalid && arready) begin
          pend = 1;
          cnt = $urandom_range(r_dly_max, r_dly_min);
        end
        if (pend && !on) begin
          if (cnt == 0) raise = 1;
          else cnt--;
        end
      end
      @(posedge clk);
      #1;
      arready = ($urandom_range(0, 99) < ar_pct);
      rid = 4'($urandom);
      if (raise) begin
        on = 1;
        dat  = fix_en ? fix_data : $urandom;
        resp = fix_en ? fix_resp : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        rdata = dat;
        rresp = resp;
        rlast = 1'($urandom);
        d_q.push_back({resp != 2'b00, dat});
      end else if (!on) begin
        rdata = $urandom;
        rresp = 2'($urandom);
      end
      rvalid = on | stray_rv;
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [1:0] sz);
    bit got;
    @(posedge clk);
    #1;
    req = 1'b1; addr = a; size = sz;
    wr = 1'($urandom); wstrb = 4'($urandom); wdata = $urandom;
    ar_q.push_back({1'b0, sz, model_map(a)});
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = addr_ok;
    end
    if (!got) chk("fetch_accepted", addr_ok, 1);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      done = (ph == 0) && !req;
    end
    if (!done) chk("idle_timeout", ph, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Minimum-latency boot fetch.
    fix_en = 1'b1; fix_data = 32'h3c1d_0000; fix_resp = 2'b00;
    fetch(32'hbfc0_0000, 2'd2);
    wait_idle();
    chk("min_latency", t_dok - t_acc, 2);

    // AR stall with a second request held behind it.
    ar_pct = 0;
    fix_en = 1'b0;
    fetch(32'h8000_1234, 2'd2);
    fork
      fetch(32'h9000_0040, 2'd1);
    join_none
    repeat (6) @(posedge clk);
    #1 ar_pct = 100;
    wait_idle();

    // Delayed R response.
    r_dly_min = 3; r_dly_max = 3;
    d0 = n_dok;
    fetch(32'h8000_0100, 2'd2);
    wait_idle();
    chk("r_delay_latency", t_dok - t_acc, 5);
    chk("single_data_ok", n_dok - d0, 1);
    r_dly_min = 0; r_dly_max = 0;

    // Error response still completes.
    fix_en = 1'b1; fix_data = 32'hdead_beef; fix_resp = 2'b10;
    e0 = n_err;
    fetch(32'ha000_0200, 2'd2);
    wait_idle();
    chk("bus_err_pulses", n_err - e0, 1);
    fix_en = 1'b0;

    // Reset while the AR is pending.
    ar_pct = 0;
    fetch(32'h8000_2000, 2'd2);
    @(negedge clk);
    chk("pre_rst_arvalid", arvalid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_addr_ok", addr_ok, 0);
    chk("mid_rst_data_ok", data_ok, 0);
    ar_pct = 100;
    fetch(32'h0040_0000, 2'd2);
    wait_idle();

    // Stray response while idle.
    stray_rv = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_rready", rready, 0);
    chk("stray_data_ok", data_ok, 0);
    chk("stray_arvalid", arvalid, 0);
    stray_rv = 1'b0;
    repeat (2) @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      ar_pct = $urandom_range(30, 100);
      r_dly_max = $urandom_range(0, 4);
      a = $urandom;
      a[31:30] = 2'($urandom_range(0, 3));
      fetch(a, 2'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    chk("all_ar_consumed", ar_q.size(), 0);
    chk("all_r_consumed", d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
